// File: rtl/insn_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// insn_prefetch_pkg
//   Shared types and constants for the instruction prefetch buffer.
//   - state_t       : prefetch controller states (IDLE, REQ, FILL, DRAIN)
//   - *_DEFAULT     : default line length and word-address width
//   - AVM_*_W       : Avalon-MM data / burstcount / byteenable widths
//   - idx_width()   : word-index width for a line, never narrower than 1 bit
// ----------------------------------------------------------------------------
package insn_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int BURST_LEN_DEFAULT = 4;
    localparam int ADDR_W_DEFAULT    = 16;

    localparam int AVM_DATA_W  = 32;
    localparam int AVM_BURST_W = 3;
    localparam int AVM_BE_W    = 4;

    // A one-word line still needs a 1-bit index so vectors stay legal.
    function automatic int idx_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/insn_prefetch_if.sv
// ----------------------------------------------------------------------------
// insn_prefetch_if
//   Bundles the CPU fetch port and the Avalon-MM ROM master port of the
//   prefetcher.
//   - slave  : view used by the prefetcher (takes fetches, drives the ROM bus)
//   - master : view used by the surrounding system (CPU + ROM model)
//   Parameter ADDR_W: word-address width of fetch_addr / avm_address.
// ----------------------------------------------------------------------------
interface insn_prefetch_if
    import insn_prefetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    // CPU side
    logic                   fetch_valid;
    logic [ADDR_W-1:0]      fetch_addr;
    logic                   fetch_ready;
    logic                   flush;
    logic                   insn_valid;
    logic [AVM_DATA_W-1:0]  insn_data;

    // Avalon-MM ROM side
    logic [ADDR_W-1:0]      avm_address;
    logic [AVM_BURST_W-1:0] avm_burstcount;
    logic                   avm_read;
    logic                   avm_write;
    logic [AVM_DATA_W-1:0]  avm_writedata;
    logic [AVM_BE_W-1:0]    avm_byteenable;
    logic                   avm_waitrequest;
    logic [AVM_DATA_W-1:0]  avm_readdata;
    logic                   avm_readdatavalid;

    modport slave (
        input  fetch_valid, fetch_addr, flush,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output fetch_ready, insn_valid, insn_data,
        output avm_address, avm_burstcount, avm_read,
        output avm_write, avm_writedata, avm_byteenable
    );

    modport master (
        output fetch_valid, fetch_addr, flush,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  fetch_ready, insn_valid, insn_data,
        input  avm_address, avm_burstcount, avm_read,
        input  avm_write, avm_writedata, avm_byteenable
    );

endinterface

// File: rtl/prefetch_line_buf.sv
// ----------------------------------------------------------------------------
// prefetch_line_buf
//   Storage for one prefetch line: BURST_LEN data words, the line tag, a
//   line-valid bit and one valid bit per word.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     inval           : drop line-valid and every word-valid bit
//     load_tag        : start a new line (new_tag), dropping all valid bits
//     wr_en/idx/data  : write one word and mark it valid
//     set_line_valid  : mark the whole line complete
//     lookup_tag      : tag to compare against the stored tag
//     rd_idx          : word index for hit test and read-out
//     hit             : line complete, tag matches and word rd_idx valid
//     rd_word         : word at rd_idx (registered by the caller)
// ----------------------------------------------------------------------------
module prefetch_line_buf
    import insn_prefetch_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int IDX_W     = idx_width(BURST_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inval,
    input  logic                  load_tag,
    input  logic [ADDR_W-1:0]     new_tag,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [AVM_DATA_W-1:0] wr_data,
    input  logic                  set_line_valid,
    input  logic [ADDR_W-1:0]     lookup_tag,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  hit,
    output logic [AVM_DATA_W-1:0] rd_word
);

    logic [AVM_DATA_W-1:0] mem [BURST_LEN];
    logic [BURST_LEN-1:0]  word_valid;
    logic [ADDR_W-1:0]     tag_reg;
    logic                  line_valid_reg;

    // Data array carries no reset; the valid bits decide what is usable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_word_valid
            logic valid_reg;
            always_ff @(posedge clk) begin
                if (reset || inval || load_tag) begin
                    valid_reg <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    valid_reg <= 1'b1;
                end
            end
            assign word_valid[gi] = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg        <= '0;
            line_valid_reg <= 1'b0;
        end else begin
            if (load_tag) begin
                tag_reg <= new_tag;
            end
            if (inval || load_tag) begin
                line_valid_reg <= 1'b0;
            end else if (set_line_valid) begin
                line_valid_reg <= 1'b1;
            end
        end
    end

    assign hit     = line_valid_reg && (tag_reg == lookup_tag) && word_valid[rd_idx];
    assign rd_word = mem[rd_idx];

endmodule

// File: rtl/insn_prefetch.sv
// ----------------------------------------------------------------------------
// insn_prefetch
//   Single-line instruction prefetch buffer in front of an Avalon-MM burst
//   ROM. A fetch hitting the buffered line returns its word the next cycle;
//   a miss refills the whole aligned line with one burst and returns the
//   requested word once. flush (branch/redirect) invalidates the line and
//   cancels any outstanding delivery; beats of a cancelled burst are drained.
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high
//     bus    : insn_prefetch_if.slave (fetch port + Avalon-MM master)
//   Parameters: BURST_LEN (words per line, power of 2, 1..4), ADDR_W.
//   Build option: define EARLY_HIT_EN to return the requested word as soon
//   as its beat arrives instead of after the final beat of the burst.
// ----------------------------------------------------------------------------
module insn_prefetch
    import insn_prefetch_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    insn_prefetch_if.slave bus
);

    localparam int                     IDX_W       = idx_width(BURST_LEN);
    localparam logic [IDX_W-1:0]       LAST_BEAT   = IDX_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]      OFFSET_MASK = ADDR_W'(BURST_LEN - 1);
    localparam logic [AVM_BURST_W-1:0] BURST_CNT   = AVM_BURST_W'(BURST_LEN);

    state_t                  state_reg;
    logic [IDX_W-1:0]        beat_cnt_reg;
    logic [IDX_W-1:0]        req_idx_reg;
    logic                    pend_reg;        // miss word still owed to the CPU
    logic                    insn_valid_reg;
    logic [AVM_DATA_W-1:0]   insn_data_reg;
    logic                    avm_read_reg;
    logic [ADDR_W-1:0]       avm_address_reg;
    logic [AVM_BURST_W-1:0]  avm_burstcount_reg;

    logic [IDX_W-1:0]        fetch_idx;
    logic [ADDR_W-1:0]       fetch_tag;
    logic                    accept;
    logic                    fill_beat;
    logic                    last_beat;
    logic                    buf_hit;
    logic [AVM_DATA_W-1:0]   buf_word;
    logic [IDX_W-1:0]        rd_idx;
    logic                    deliver;
    logic [AVM_DATA_W-1:0]   deliver_data;

    assign fetch_idx = bus.fetch_addr[IDX_W-1:0] & LAST_BEAT;
    assign fetch_tag = bus.fetch_addr & ~OFFSET_MASK;
    assign accept    = (state_reg == IDLE) && bus.fetch_valid && !bus.flush;
    assign fill_beat = (state_reg == FILL) && bus.avm_readdatavalid;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

    // In IDLE the buffer answers the incoming fetch; otherwise it serves the
    // word owed to the pending miss.
    assign rd_idx = (state_reg == IDLE) ? fetch_idx : req_idx_reg;

`ifdef EARLY_HIT_EN
    assign deliver      = pend_reg && fill_beat && !bus.flush && (beat_cnt_reg == req_idx_reg);
    assign deliver_data = bus.avm_readdata;
`else
    assign deliver      = pend_reg && fill_beat && !bus.flush && last_beat;
    // The requested word may be the beat being written this very cycle.
    assign deliver_data = (req_idx_reg == beat_cnt_reg) ? bus.avm_readdata : buf_word;
`endif

    prefetch_line_buf #(
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W)
    ) u_line_buf (
        .clk            (clk),
        .reset          (reset),
        .inval          (bus.flush),
        .load_tag       (accept && !buf_hit),
        .new_tag        (fetch_tag),
        .wr_en          (fill_beat && !bus.flush),
        .wr_idx         (beat_cnt_reg),
        .wr_data        (bus.avm_readdata),
        .set_line_valid (fill_beat && !bus.flush && last_beat),
        .lookup_tag     (fetch_tag),
        .rd_idx         (rd_idx),
        .hit            (buf_hit),
        .rd_word        (buf_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            beat_cnt_reg       <= '0;
            req_idx_reg        <= '0;
            pend_reg           <= 1'b0;
            insn_valid_reg     <= 1'b0;
            insn_data_reg      <= '0;
            avm_read_reg       <= 1'b0;
            avm_address_reg    <= '0;
            avm_burstcount_reg <= '0;
        end else begin
            insn_valid_reg <= 1'b0;

            if (deliver) begin
                insn_valid_reg <= 1'b1;
                insn_data_reg  <= deliver_data;
                pend_reg       <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (buf_hit) begin
                            insn_valid_reg <= 1'b1;
                            insn_data_reg  <= buf_word;
                        end else begin
                            state_reg          <= REQ;
                            avm_read_reg       <= 1'b1;
                            avm_address_reg    <= fetch_tag;
                            avm_burstcount_reg <= BURST_CNT;
                            req_idx_reg        <= fetch_idx;
                            beat_cnt_reg       <= '0;
                            pend_reg           <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    // The command must complete even if flushed; a burst that
                    // lost its pending miss is drained instead of filled.
                    if (!bus.avm_waitrequest) begin
                        avm_read_reg <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= (pend_reg && !bus.flush) ? FILL : DRAIN;
                    end
                end

                FILL, DRAIN: begin
                    if (bus.avm_readdatavalid) begin
                        beat_cnt_reg <= beat_cnt_reg + IDX_W'(1);
                        if (last_beat) begin
                            beat_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else if (bus.flush) begin
                            state_reg <= DRAIN;
                        end
                    end else if (bus.flush) begin
                        state_reg <= DRAIN;
                    end
                end

                default: state_reg <= IDLE;
            endcase

            if (bus.flush) begin
                pend_reg <= 1'b0;
            end
        end
    end

    assign bus.fetch_ready    = (state_reg == IDLE) && !bus.flush;
    assign bus.insn_valid     = insn_valid_reg;
    assign bus.insn_data      = insn_data_reg;
    assign bus.avm_read       = avm_read_reg;
    assign bus.avm_address    = avm_address_reg;
    assign bus.avm_burstcount = avm_burstcount_reg;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_writedata  = '0;
    assign bus.avm_byteenable = '1;

endmodule

// File: tb/tb_insn_prefetch.sv
// ----------------------------------------------------------------------------
// tb_insn_prefetch
//   Directed stimulus for insn_prefetch. Expected instruction words, expected
//   Avalon commands and expected signal probes are queued by the stimulus
//   process; a negedge monitor pops and compares them as the DUT presents
//   them.
// ----------------------------------------------------------------------------
module tb_insn_prefetch;
    import insn_prefetch_pkg::*;

`ifdef EARLY_HIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam int K_FETCH_READY = 0;
    localparam int K_INSN_VALID  = 1;
    localparam int K_INSN_DATA   = 2;
    localparam int K_AVM_READ    = 3;
    localparam int K_AVM_ADDR    = 4;
    localparam int K_AVM_BC      = 5;
    localparam int K_AVM_WRITE   = 6;
    localparam int K_AVM_WDATA   = 7;
    localparam int K_AVM_BE      = 8;

    localparam logic [31:0] A0 = 32'hA000_00A0, A1 = 32'hA000_00A1, A2 = 32'hA000_00A2, A3 = 32'hA000_00A3;
    localparam logic [31:0] B0 = 32'hB000_00B0, B1 = 32'hB000_00B1, B2 = 32'hB000_00B2, B3 = 32'hB000_00B3;
    localparam logic [31:0] C0 = 32'hC000_00C0, C1 = 32'hC000_00C1, C2 = 32'hC000_00C2, C3 = 32'hC000_00C3;
    localparam logic [31:0] D0 = 32'hD000_00D0, D1 = 32'hD000_00D1, D2 = 32'hD000_00D2, D3 = 32'hD000_00D3;
    localparam logic [31:0] E0 = 32'hE000_00E0, E1 = 32'hE000_00E1, E2 = 32'hE000_00E2, E3 = 32'hE000_00E3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } probe_t;

    logic clk;
    logic reset;
    logic done;

    logic [31:0] insn_q[$];
    logic [18:0] cmd_q[$];      // {avm_address, avm_burstcount}
    probe_t      probe_q[$];

    int checks;
    int errors;

    insn_prefetch_if #(.ADDR_W(16)) bus ();

    insn_prefetch #(
        .BURST_LEN (4),
        .ADDR_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic string kind_name(input int kind);
        case (kind)
            K_FETCH_READY: return "fetch_ready";
            K_INSN_VALID:  return "insn_valid";
            K_INSN_DATA:   return "insn_data";
            K_AVM_READ:    return "avm_read";
            K_AVM_ADDR:    return "avm_address";
            K_AVM_BC:      return "avm_burstcount";
            K_AVM_WRITE:   return "avm_write";
            K_AVM_WDATA:   return "avm_writedata";
            K_AVM_BE:      return "avm_byteenable";
            default:       return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] kind_actual(input int kind);
        case (kind)
            K_FETCH_READY: return {31'b0, bus.fetch_ready};
            K_INSN_VALID:  return {31'b0, bus.insn_valid};
            K_INSN_DATA:   return bus.insn_data;
            K_AVM_READ:    return {31'b0, bus.avm_read};
            K_AVM_ADDR:    return {16'b0, bus.avm_address};
            K_AVM_BC:      return {29'b0, bus.avm_burstcount};
            K_AVM_WRITE:   return {31'b0, bus.avm_write};
            K_AVM_WDATA:   return bus.avm_writedata;
            K_AVM_BE:      return {28'b0, bus.avm_byteenable};
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor / scoreboard: the only process that counts comparisons.
    initial begin
        logic [31:0] exp_data;
        logic [18:0] exp_cmd;
        logic [31:0] act;
        probe_t      p;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            if (bus.insn_valid === 1'b1) begin
                checks++;
                if (insn_q.size() == 0) begin
                    errors++;
                    $display("FAIL insn_unexpected: insn_valid=1 data=%h, required no pulse", bus.insn_data);
                end else begin
                    exp_data = insn_q.pop_front();
                    if (bus.insn_data !== exp_data) begin
                        errors++;
                        $display("FAIL insn_data: got %h, required %h", bus.insn_data, exp_data);
                    end else begin
                        $display("insn  data=%h ok", bus.insn_data);
                    end
                end
            end
            if (bus.avm_read === 1'b1 && bus.avm_waitrequest === 1'b0) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL avm_cmd_unexpected: read addr=%h bc=%0d, required no command",
                             bus.avm_address, bus.avm_burstcount);
                end else begin
                    exp_cmd = cmd_q.pop_front();
                    if ({bus.avm_address, bus.avm_burstcount} !== exp_cmd) begin
                        errors++;
                        $display("FAIL avm_cmd: got addr=%h bc=%0d, required addr=%h bc=%0d",
                                 bus.avm_address, bus.avm_burstcount, exp_cmd[18:3], exp_cmd[2:0]);
                    end else begin
                        $display("cmd   addr=%h bc=%0d ok", bus.avm_address, bus.avm_burstcount);
                    end
                end
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                act = kind_actual(p.kind);
                checks++;
                if (act !== p.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", kind_name(p.kind), act, p.exp);
                end else begin
                    $display("probe %s=%h ok", kind_name(p.kind), act);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (insn_q.size() != 0) begin
                    errors++;
                    $display("FAIL insn_missing: %0d pulses outstanding, required 0", insn_q.size());
                end
                checks++;
                if (cmd_q.size() != 0) begin
                    errors++;
                    $display("FAIL cmd_missing: %0d commands outstanding, required 0", cmd_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int kind, input logic [31:0] exp);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic beat(input logic [31:0] d);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = d;
        tick();
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
    endtask

    task automatic fetch_cmd(input logic [15:0] addr);
        cmd_q.push_back({addr, 3'd4});
    endtask

    // Stimulus
    initial begin
        done                  = 1'b0;
        reset                 = 1'b1;
        bus.fetch_valid       = 1'b0;
        bus.fetch_addr        = '0;
        bus.flush             = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        tick();
        tick();

        // Reset state
        probe(K_INSN_VALID, 0);
        probe(K_INSN_DATA, 0);
        probe(K_AVM_READ, 0);
        probe(K_AVM_ADDR, 0);
        probe(K_AVM_BC, 0);
        probe(K_AVM_WRITE, 0);
        probe(K_AVM_WDATA, 0);
        probe(K_AVM_BE, 32'hF);
        tick();
        reset = 1'b0;
        probe(K_FETCH_READY, 1);
        tick();

        // Cold miss on 0x0012, command stalled for two cycles
        bus.fetch_valid     = 1'b1;
        bus.fetch_addr      = 16'h0012;
        bus.avm_waitrequest = 1'b1;
        probe(K_FETCH_READY, 1);
        fetch_cmd(16'h0010);
        insn_q.push_back(A2);
        tick();
        bus.fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.avm_waitrequest = 1'b0;
            probe(K_AVM_READ, 1);
            probe(K_AVM_ADDR, 32'h0010);
            probe(K_AVM_BC, 4);
            probe(K_FETCH_READY, 0);
            tick();
        end
        bus.avm_waitrequest = 1'b1;
        probe(K_AVM_READ, 0);
        beat(A0);
        beat(A1);
        beat(A2);
        probe(K_INSN_VALID, EARLY ? 32'd1 : 32'd0);
        beat(A3);
        probe(K_INSN_VALID, EARLY ? 32'd0 : 32'd1);
        probe(K_FETCH_READY, 1);

        // Hits on the filled line, back to back
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 16'h0013;
        insn_q.push_back(A3);
        tick();
        probe(K_INSN_VALID, 1);
        probe(K_INSN_DATA, A3);
        probe(K_AVM_READ, 0);
        bus.fetch_addr = 16'h0010;
        insn_q.push_back(A0);
        tick();
        bus.fetch_addr = 16'h0011;
        insn_q.push_back(A1);
        tick();
        bus.fetch_valid = 1'b0;
        probe(K_INSN_DATA, A1);
        tick();

        // flush together with fetch_valid: not accepted
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 16'h0020;
        bus.flush       = 1'b1;
        probe(K_FETCH_READY, 0);
        tick();
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b0;
        probe(K_AVM_READ, 0);
        probe(K_INSN_VALID, 0);
        probe(K_FETCH_READY, 1);
        tick();

        // Line was invalidated by the flush: 0x0011 misses; flush after one beat
        bus.fetch_valid     = 1'b1;
        bus.fetch_addr      = 16'h0011;
        bus.avm_waitrequest = 1'b0;
        fetch_cmd(16'h0010);
        tick();
        bus.fetch_valid = 1'b0;
        probe(K_AVM_READ, 1);
        tick();
        probe(K_AVM_READ, 0);
        beat(B0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        probe(K_FETCH_READY, 0);
        beat(B1);
        probe(K_FETCH_READY, 0);
        beat(B2);
        probe(K_FETCH_READY, 0);
        beat(B3);
        probe(K_FETCH_READY, 1);
        probe(K_INSN_VALID, 0);

        // Miss on 0x0010, flush while the command is stalled
        bus.fetch_valid     = 1'b1;
        bus.fetch_addr      = 16'h0010;
        bus.avm_waitrequest = 1'b1;
        fetch_cmd(16'h0010);
        tick();
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b1;
        probe(K_AVM_READ, 1);
        tick();
        bus.flush = 1'b0;
        probe(K_AVM_READ, 1);
        probe(K_AVM_ADDR, 32'h0010);
        tick();
        bus.avm_waitrequest = 1'b0;
        probe(K_AVM_READ, 1);
        tick();
        bus.avm_waitrequest = 1'b1;
        probe(K_AVM_READ, 0);
        probe(K_FETCH_READY, 0);
        beat(C0);
        beat(C1);
        beat(C2);
        probe(K_FETCH_READY, 0);
        beat(C3);
        probe(K_FETCH_READY, 1);
        probe(K_INSN_VALID, 0);

        // Line-valid dropped: 0x0012 misses; reset after two beats
        bus.fetch_valid     = 1'b1;
        bus.fetch_addr      = 16'h0012;
        bus.avm_waitrequest = 1'b0;
        fetch_cmd(16'h0010);
        tick();
        bus.fetch_valid = 1'b0;
        probe(K_AVM_READ, 1);
        tick();
        beat(D0);
        beat(D1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        probe(K_INSN_VALID, 0);
        probe(K_INSN_DATA, 0);
        probe(K_AVM_READ, 0);
        probe(K_AVM_ADDR, 0);
        probe(K_AVM_BC, 0);
        probe(K_FETCH_READY, 1);
        beat(D2);
        probe(K_FETCH_READY, 1);
        beat(D3);
        probe(K_FETCH_READY, 1);
        probe(K_INSN_VALID, 0);

        // After reset 0x0010 is a miss and refills the line
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 16'h0010;
        fetch_cmd(16'h0010);
        insn_q.push_back(E0);
        tick();
        bus.fetch_valid = 1'b0;
        probe(K_AVM_READ, 1);
        tick();
        beat(E0);
        probe(K_INSN_VALID, EARLY ? 32'd1 : 32'd0);
        beat(E1);
        beat(E2);
        beat(E3);
        probe(K_INSN_VALID, EARLY ? 32'd0 : 32'd1);
        probe(K_FETCH_READY, 1);
        tick();

        // Hit on the refilled line
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 16'h0013;
        insn_q.push_back(E3);
        tick();
        bus.fetch_valid = 1'b0;
        probe(K_INSN_VALID, 1);
        probe(K_INSN_DATA, E3);
        probe(K_AVM_READ, 0);
        tick();
        tick();
        done = 1'b1;
    end

endmodule
